// File: rtl/fifo_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter_if
// Purpose  : Handshake bundle between the round-robin arbiter, the input FIFO
//            bank (empty/data/pop) and the output FIFO bank (alm_full/push).
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rr_arbiter_if #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = 8
);
   logic                  enb;
   logic [3:0]            in_empty;
   logic [4*DATA_W-1:0]   in_data;
   logic [3:0]            out_alm_full;
   logic [3:0]            pop;
   logic [3:0]            push;
   logic [DATA_W-1:0]     data_out;
   logic [4*CNT_W-1:0]    push_cnt;
   logic                  idle;

   // Arbiter side
   modport master (
      input  enb, in_empty, in_data, out_alm_full,
      output pop, push, data_out, push_cnt, idle
   );

   // FIFO banks / controller side
   modport slave (
      output enb, in_empty, in_data, out_alm_full,
      input  pop, push, data_out, push_cnt, idle
   );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter
// Purpose  : Round-robin drain of four input FIFOs, routing each word to one of
//            four output FIFOs selected by the word's two MSBs.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
   parameter int DATA_W = 10,
   parameter int CNT_W  = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   fifo_rr_arbiter_if.master      bus
);

   localparam int c_NUM = 4;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t              r_state;
   logic [1:0]          r_rr_ptr;
   logic                r_pend_vld;
   logic [1:0]          r_pend_src;
   logic [CNT_W-1:0]    r_cnt [c_NUM];

   logic [DATA_W-1:0]   w_word [c_NUM];
   logic                w_can_grant;
   logic                w_gnt_vld;
   logic [1:0]          w_gnt_idx;
   logic [1:0]          w_scan;
   logic                w_route_vld;
   logic [DATA_W-1:0]   w_route_word;
   logic [1:0]          w_dest;

   genvar gi;
   generate
      for (gi = 0; gi < c_NUM; gi++) begin : g_lane
         assign w_word[gi] = bus.in_data[gi*DATA_W +: DATA_W];
         assign bus.push_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];
      end
   endgenerate

   // Scan from the farthest offset down so the first non-empty FIFO at or
   // after rr_ptr is the one left selected.
   always_comb begin
      w_can_grant = (r_state == S_ACTIVE) && !rst &&
                    !(&bus.in_empty) && !(|bus.out_alm_full);
      w_gnt_vld   = 1'b0;
      w_gnt_idx   = r_rr_ptr;
      w_scan      = 2'd0;
      for (int k = c_NUM - 1; k >= 0; k--) begin
         w_scan = r_rr_ptr + 2'(k);
         if (!bus.in_empty[w_scan]) begin
            w_gnt_vld = w_can_grant;
            w_gnt_idx = w_scan;
         end
      end
   end

   assign bus.pop = w_gnt_vld ? (4'b0001 << w_gnt_idx) : 4'b0000;

   // The popped word appears on the FIFO's registered output one cycle later.
   assign w_route_word = w_word[r_pend_src];
   assign w_dest       = w_route_word[DATA_W-1 -: 2];
   assign w_route_vld  = r_pend_vld && !rst;

   assign bus.push     = w_route_vld ? (4'b0001 << w_dest) : 4'b0000;
   assign bus.data_out = w_route_vld ? w_route_word : '0;
   assign bus.idle     = (r_state == S_IDLE) && !r_pend_vld && (&bus.in_empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= 2'd0;
         r_pend_vld <= 1'b0;
         r_pend_src <= 2'd0;
         for (int j = 0; j < c_NUM; j++) begin
            r_cnt[j] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE:   if (bus.enb)  r_state <= S_ACTIVE;
            S_ACTIVE: if (!bus.enb) r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase

         r_pend_vld <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_rr_ptr   <= w_gnt_idx + 2'd1;
            r_pend_src <= w_gnt_idx;
         end

         if (w_route_vld) begin
            r_cnt[w_dest] <= r_cnt[w_dest] + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
